// File: rtl/axis_packet_arbiter.sv
// rtl/axis_packet_arbiter.sv - round-robin packet arbiter merging N AXI-Stream inputs onto one registered output
module axis_packet_arbiter #(
    parameter int N_INPUTS   = 4,
    parameter int AXIS_BYTES = 1
) (
    input  logic                             clk,
    input  logic                             sresetn,
    input  logic [N_INPUTS-1:0]              axis_i_tvalid,
    output logic [N_INPUTS-1:0]              axis_i_tready,
    input  logic [N_INPUTS-1:0]              axis_i_tlast,
    input  logic [N_INPUTS*AXIS_BYTES*8-1:0] axis_i_tdata,
    output logic                             axis_o_tvalid,
    input  logic                             axis_o_tready,
    output logic                             axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]          axis_o_tdata,
    output logic [$clog2(N_INPUTS)-1:0]      grant_id,
    output logic                             grant_active
);
    localparam int GRANT_WIDTH = $clog2(N_INPUTS);
    localparam int DW          = AXIS_BYTES * 8;
    localparam logic [GRANT_WIDTH:0]   N_VAL  = (GRANT_WIDTH+1)'(N_INPUTS);
    localparam logic [GRANT_WIDTH-1:0] G_LAST = GRANT_WIDTH'(N_INPUTS - 1);
    localparam logic [GRANT_WIDTH-1:0] G_ONE  = GRANT_WIDTH'(1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [1:0]               r_rst_sync;
    logic                     w_rst_n;
    logic [GRANT_WIDTH-1:0]   r_grant;
    logic [GRANT_WIDTH-1:0]   r_rr_ptr;
    logic                     r_o_tvalid;
    logic                     r_o_tlast;
    logic [DW-1:0]            r_o_tdata;
    logic [N_INPUTS-1:0]      w_vld_rot;
    logic [GRANT_WIDTH-1:0]   w_offset;
    logic [GRANT_WIDTH:0]     w_sum;
    logic [GRANT_WIDTH-1:0]   w_pick;
    logic                     w_gnt_valid;
    logic                     w_gnt_last;
    logic [DW-1:0]            w_gnt_data;
    logic                     w_out_free;
    logic                     w_accept;
    logic [N_INPUTS-1:0]      w_ready;

    // Reset asserts asynchronously but releases two edges after sresetn rises.
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    // Rotate requests so bit 0 is the rr_ptr input; first set bit is the winner offset.
    assign w_vld_rot = N_INPUTS'({axis_i_tvalid, axis_i_tvalid} >> r_rr_ptr);

    always_comb begin
        w_offset = '0;
        for (int i = N_INPUTS - 1; i >= 0; i--) begin
            if (w_vld_rot[i]) begin
                w_offset = GRANT_WIDTH'(i);
            end
        end
    end

    assign w_sum  = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    assign w_pick = GRANT_WIDTH'((w_sum >= N_VAL) ? (w_sum - N_VAL) : w_sum);

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_last  = 1'b0;
        w_gnt_data  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (r_grant == GRANT_WIDTH'(i)) begin
                w_gnt_valid = axis_i_tvalid[i];
                w_gnt_last  = axis_i_tlast[i];
                w_gnt_data  = axis_i_tdata[i*DW +: DW];
            end
        end
    end

    assign w_out_free = !r_o_tvalid || axis_o_tready;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|axis_i_tvalid) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                for (int i = 0; i < N_INPUTS; i++) begin
                    if (r_grant == GRANT_WIDTH'(i)) begin
                        w_ready[i] = w_out_free;
                    end
                end
                w_accept = w_gnt_valid && w_out_free;
                if (w_accept && w_gnt_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_o_tvalid <= 1'b0;
            r_o_tlast  <= 1'b0;
            r_o_tdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && |axis_i_tvalid) begin
                r_grant <= w_pick;
            end
            if (w_accept && w_gnt_last) begin
                r_rr_ptr <= (r_grant == G_LAST) ? '0 : r_grant + G_ONE;
            end
            if (w_accept) begin
                r_o_tvalid <= 1'b1;
                r_o_tlast  <= w_gnt_last;
                r_o_tdata  <= w_gnt_data;
            end else if (axis_o_tready) begin
                r_o_tvalid <= 1'b0;
            end
        end
    end

    assign axis_i_tready = w_ready;
    assign axis_o_tvalid = r_o_tvalid;
    assign axis_o_tlast  = r_o_tlast;
    assign axis_o_tdata  = r_o_tdata;
    assign grant_id      = r_grant;
    assign grant_active  = (r_state == S_ACTIVE);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb/tb_axis_packet_arbiter.sv - self-checking bench for axis_packet_arbiter
`timescale 1ns/1ps
module tb_axis_packet_arbiter;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        sresetn;
    logic [3:0]  i_valid, i_ready, i_last;
    logic [31:0] i_data;
    logic        o_valid, o_ready, o_last;
    logic [7:0]  o_data;
    logic [1:0]  gid;
    logic        gact;

    logic [2:0]  v3, r3, l3;
    logic [23:0] d3;
    logic        ov3, ol3;
    logic [7:0]  od3;
    logic [1:0]  gid3;
    logic        gact3;

    int errors = 0;
    int checks = 0;

    axis_packet_arbiter #(.N_INPUTS(4), .AXIS_BYTES(1)) dut (
        .clk(clk), .sresetn(sresetn),
        .axis_i_tvalid(i_valid), .axis_i_tready(i_ready), .axis_i_tlast(i_last), .axis_i_tdata(i_data),
        .axis_o_tvalid(o_valid), .axis_o_tready(o_ready), .axis_o_tlast(o_last), .axis_o_tdata(o_data),
        .grant_id(gid), .grant_active(gact)
    );

    axis_packet_arbiter #(.N_INPUTS(3), .AXIS_BYTES(1)) dut3 (
        .clk(clk), .sresetn(sresetn),
        .axis_i_tvalid(v3), .axis_i_tready(r3), .axis_i_tlast(l3), .axis_i_tdata(d3),
        .axis_o_tvalid(ov3), .axis_o_tready(1'b1), .axis_o_tlast(ol3), .axis_o_tdata(od3),
        .grant_id(gid3), .grant_active(gact3)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  e_ready;
        logic        e_ovalid;
        logic        e_olast;
        logic [7:0]  e_odata;
        logic        e_act;
        logic [1:0]  e_gid;
    } vec_t;
    vec_t tbl[6];

    logic [8:0] beats[4][64];
    int         len[4];
    int         pos[4];
    bit         mid[4];
    logic [8:0] exp_q[$];
    int         ord_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        sresetn = 1'b0;
        i_valid = '0; i_last = '0; i_data = '0; o_ready = 1'b1;
        v3 = '0; l3 = '0; d3 = '0;
        repeat (2) @(negedge clk);
        sresetn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Expected output is derived at packet level: round-robin over inputs with pending packets.
    task automatic run_traffic(input int cfg, input int rmode);
        int npk, total, acc, cyc, idle, rr, n, p;
        int tmp[4];
        bit seen_act, prev_act, stall_prev;
        logic [7:0] prev_d;
        logic       prev_l;
        logic [8:0] b, e;
        do_reset();
        exp_q.delete();
        ord_q.delete();
        npk = 0; total = 0;
        for (int i = 0; i < 4; i++) begin
            int np, nb;
            len[i] = 0; pos[i] = 0; mid[i] = 0;
            np = (cfg == 0) ? ((i == 0) ? 2 : 1) : int'($urandom_range(0, 3));
            for (int k = 0; k < np; k++) begin
                nb = (cfg == 0) ? 2 : int'($urandom_range(1, 4));
                for (int j = 0; j < nb; j++) begin
                    beats[i][len[i]] = {(j == nb - 1), 8'($urandom)};
                    len[i]++;
                end
            end
            total += len[i];
        end
        for (int i = 0; i < 4; i++) tmp[i] = 0;
        rr = 0;
        while (1) begin
            n = -1;
            for (int k = 0; k < 4; k++) begin
                p = (rr + k) % 4;
                if (n < 0 && tmp[p] < len[p]) n = p;
            end
            if (n < 0) break;
            ord_q.push_back(n);
            npk++;
            do begin
                b = beats[n][tmp[n]];
                tmp[n]++;
                exp_q.push_back(b);
            end while (!b[8]);
            rr = (n + 1) % 4;
        end

        acc = 0; cyc = 0; idle = 0;
        seen_act = 0; prev_act = 0; stall_prev = 0; prev_d = '0; prev_l = 1'b0;
        while ((exp_q.size() > 0 || acc < total) && cyc < 4000) begin
            @(negedge clk);
            case (rmode)
                0:       o_ready = 1'b1;
                1:       o_ready = cyc[0];
                default: o_ready = 1'($urandom_range(0, 1));
            endcase
            for (int i = 0; i < 4; i++) begin
                if (pos[i] < len[i] && !(mid[i] && $urandom_range(0, 3) == 0)) begin
                    i_valid[i] = 1'b1;
                    i_last[i]  = beats[i][pos[i]][8];
                    i_data[i*8 +: 8] = beats[i][pos[i]][7:0];
                end else begin
                    i_valid[i] = 1'b0;
                    i_last[i]  = 1'($urandom_range(0, 1));
                    i_data[i*8 +: 8] = 8'($urandom);
                end
            end
            #1;
            chk("tready only on grant", i_ready & ~(4'b0001 << gid), 0);
            if (stall_prev) chk("stall hold", {o_valid, o_last, o_data}, {1'b1, prev_l, prev_d});
            if (gact && !prev_act) begin
                if (ord_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL grant order: got extra grant %0d, required none", gid);
                end else begin
                    chk("grant order", gid, ord_q.pop_front());
                end
            end
            if (seen_act && !gact && acc < total) idle++;
            if (gact) seen_act = 1;
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out beat: got extra beat 0x%0h, required none", {o_last, o_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("out beat", {o_last, o_data}, e);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (i_valid[i] && i_ready[i]) begin
                    mid[i] = !beats[i][pos[i]][8];
                    pos[i]++;
                    acc++;
                end
            end
            stall_prev = o_valid && !o_ready;
            prev_d = o_data; prev_l = o_last; prev_act = gact;
            cyc++;
        end
        chk("traffic complete", (exp_q.size() == 0 && acc == total), 1);
        if (npk > 0) chk("idle cycles", idle, npk - 1);
        chk("grants left", ord_q.size(), 0);
    endtask

    initial begin
        tbl[0] = '{4'b0100, 4'b0000, 32'h0011_0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};
        tbl[1] = '{4'b0100, 4'b0000, 32'h0011_0000, 1'b1, 4'b0100, 1'b0, 1'b0, 8'h00, 1'b1, 2'd2};
        tbl[2] = '{4'b0100, 4'b0000, 32'h0022_0000, 1'b1, 4'b0100, 1'b1, 1'b0, 8'h11, 1'b1, 2'd2};
        tbl[3] = '{4'b0100, 4'b0100, 32'h0033_0000, 1'b1, 4'b0100, 1'b1, 1'b0, 8'h22, 1'b1, 2'd2};
        tbl[4] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 1'b1, 8'h33, 1'b0, 2'd2};
        tbl[5] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 1'b1, 8'h33, 1'b0, 2'd2};

        sresetn = 1'b1;
        i_valid = '0; i_last = '0; i_data = '0; o_ready = 1'b1;
        v3 = '0; l3 = '0; d3 = '0;
        repeat (2) @(negedge clk);
        sresetn = 1'b0;
        #1;
        chk("reset o_valid", o_valid, 0);
        chk("reset o_last", o_last, 0);
        chk("reset o_data", o_data, 0);
        chk("reset i_ready", i_ready, 0);
        chk("reset active", gact, 0);
        chk("reset grant", gid, 0);
        chk("reset n3 i_ready", r3, 0);

        i_valid = 4'b1111; i_last = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        sresetn = 1'b1;
        @(posedge clk); #1;
        chk("sync edge1 active", gact, 0);
        @(posedge clk); @(posedge clk); #1;
        chk("sync later active", gact, 1);
        chk("sync first grant", gid, 0);

        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            i_valid = tbl[k].valid; i_last = tbl[k].last; i_data = tbl[k].data; o_ready = tbl[k].ordy;
            #1;
            chk($sformatf("tbl%0d i_ready", k), i_ready, tbl[k].e_ready);
            chk($sformatf("tbl%0d o_valid", k), o_valid, tbl[k].e_ovalid);
            chk($sformatf("tbl%0d o_last", k), o_last, tbl[k].e_olast);
            chk($sformatf("tbl%0d o_data", k), o_data, tbl[k].e_odata);
            chk($sformatf("tbl%0d active", k), gact, tbl[k].e_act);
            chk($sformatf("tbl%0d grant", k), gid, tbl[k].e_gid);
        end

        do_reset();
        @(negedge clk);
        i_valid = 4'b0010; i_last = 4'b0000; i_data = 32'h0000_A100;
        @(negedge clk); #1;
        chk("hold grant1 id", gid, 1);
        chk("hold grant1 active", gact, 1);
        repeat (3) begin
            @(negedge clk);
            i_valid = 4'b1000; i_last = 4'b0000; i_data = 32'h3300_0000;
            #1;
            chk("hold gap i_ready", i_ready, 4'b0010);
            chk("hold gap grant", gid, 1);
        end
        @(negedge clk);
        i_valid = 4'b1010; i_last = 4'b0010; i_data = 32'h3300_A200;
        #1;
        chk("hold resume i_ready", i_ready, 4'b0010);
        @(negedge clk);
        i_valid = 4'b1000; i_last = 4'b0000; i_data = 32'h3300_0000;
        #1;
        chk("hold idle active", gact, 0);
        chk("hold last beat", {o_valid, o_last, o_data}, {1'b1, 1'b1, 8'hA2});
        @(negedge clk);
        o_ready = 1'b0;
        #1;
        chk("hold then grant3", gid, 3);
        chk("grant3 i_ready", i_ready, 4'b1000);
        @(negedge clk); #1;
        chk("stalled out", {o_valid, o_data}, {1'b1, 8'h33});
        chk("stalled i_ready", i_ready, 0);
        #2 sresetn = 1'b0;
        #1;
        chk("async rst o_valid", o_valid, 0);
        chk("async rst i_ready", i_ready, 0);
        chk("async rst active", gact, 0);
        chk("async rst grant", gid, 0);
        chk("async rst data", {o_last, o_data}, 0);
        i_valid = 4'b1111; i_last = 4'b0000; o_ready = 1'b1;
        @(negedge clk);
        sresetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post rst grant", gid, 0);
        chk("post rst active", gact, 1);

        do_reset();
        @(negedge clk);
        v3 = 3'b100; l3 = 3'b100; d3 = 24'hC2_0000;
        @(negedge clk); #1;
        chk("n3 grant2", gid3, 2);
        chk("n3 i_ready2", r3, 3'b100);
        @(negedge clk);
        v3 = 3'b101; l3 = 3'b101; d3 = 24'hC2_00C0;
        #1;
        chk("n3 idle", gact3, 0);
        chk("n3 out C2", {ov3, od3}, {1'b1, 8'hC2});
        @(negedge clk); #1;
        chk("n3 wrap grant0", gid3, 0);
        chk("n3 i_ready0", r3, 3'b001);
        @(negedge clk);
        v3 = 3'b100;
        #1;
        chk("n3 out C0", {ov3, ol3, od3}, {1'b1, 1'b1, 8'hC0});
        @(negedge clk); #1;
        chk("n3 regrant2", gid3, 2);

        run_traffic(0, 0);
        run_traffic(1, 1);
        for (int t = 0; t < 6; t++) run_traffic(1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
